// File: rtl/cim_macro_bitserial_pkg.sv
// Shared types and width helpers for the bit-serial compute-in-memory macro.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } state_e;

  function automatic int pcw_f(input int rows);
    return $clog2(rows + 1);
  endfunction

  // One extra bit over popcount+shift headroom carries the sign.
  function automatic int acc_w_f(input int rows, input int in_bits);
    return pcw_f(rows) + in_bits + 1;
  endfunction

  function automatic int lane_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cim_macro_bitserial_if.sv
// Weight-write port plus input/output streams of the CIM macro.
interface cim_macro_bitserial_if
  import cim_pkg::*;
#(
  parameter int ROWS    = 128,
  parameter int COLS    = 64,
  parameter int IN_BITS = 4
) ();

  localparam int ACC_W = acc_w_f(ROWS, IN_BITS);
  localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  // A transfer happens on a rising edge where valid && ready; the source holds
  // valid and its payload stable until then, and ready never waits on valid.
  logic                     WE;
  logic                     w_ready;
  logic [AW-1:0]            w_addr;
  logic [COLS-1:0]          w_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*IN_BITS-1:0]  In_B;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*ACC_W-1:0]    DOut;

  modport master (
    output WE, w_addr, w_data, in_valid, In_B, out_ready,
    input  w_ready, in_ready, out_valid, DOut
  );

  modport slave (
    input  WE, w_addr, w_data, in_valid, In_B, out_ready,
    output w_ready, in_ready, out_valid, DOut
  );

endinterface

// File: rtl/cim_macro_bitserial_col_mac.sv
// One column: popcount of (input bit-plane AND weight column), signed shift-accumulate.
module cim_col_mac
  import cim_pkg::*;
#(
  parameter int ROWS    = 128,
  parameter int IN_BITS = 4,
  parameter int PCW     = pcw_f(ROWS),
  parameter int ACC_W   = acc_w_f(ROWS, IN_BITS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_step,
  input  logic                    i_neg,
  input  logic [ROWS-1:0]         i_plane,
  input  logic [ROWS-1:0]         i_wcol,
  output logic signed [ACC_W-1:0] o_acc_next
);

  logic [PCW-1:0]          w_pc;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] r_acc;

  always_comb begin
    w_pc = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_pc = w_pc + PCW'(i_plane[r] & i_wcol[r]);
    end
  end

  always_comb begin
    w_term = $signed({{(ACC_W - PCW){1'b0}}, w_pc});
    if (i_neg) begin
      w_term = -w_term;
    end
  end

  // Next value is exported so the top can capture the final plane on the same edge.
  always_comb begin
    o_acc_next = r_acc;
    if (i_clear) begin
      o_acc_next = '0;
    end else if (i_step) begin
      o_acc_next = (r_acc <<< 1) + w_term;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/cim_macro_bitserial.sv
// Binary-weight CIM macro: bit-serial MSB-first input, per-column popcount MAC, valid/ready streams.
module cim_macro_bitserial
  import cim_pkg::*;
#(
  parameter int ROWS      = 128,
  parameter int COLS      = 64,
  parameter int IN_BITS   = 4,
  parameter int SIGNED_IN = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  cim_macro_bitserial_if.slave  bus,
  output state_e                o_dbg_state
);

  localparam int ACC_W = acc_w_f(ROWS, IN_BITS);
  localparam int BW    = $clog2(IN_BITS);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [BW-1:0]           r_bit;
  logic [ROWS*IN_BITS-1:0] r_in;
  logic [COLS*ACC_W-1:0]   r_dout;
  logic [COLS-1:0]         r_wmem [ROWS];

  logic                    w_accept;
  logic                    w_clear;
  logic                    w_step;
  logic                    w_neg;
  logic                    w_last;
  logic [ROWS-1:0]         w_plane;
  logic [ROWS-1:0]         w_wcol [COLS];
  logic [COLS*ACC_W-1:0]   w_acc_next;

  assign bus.w_ready   = (r_state == IDLE);
  assign bus.in_ready  = (r_state == IDLE) && !bus.WE;
  assign bus.out_valid = (r_state == OUT);
  assign bus.DOut      = r_dout;
  assign o_dbg_state   = r_state;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last   = (r_bit == '0);
  // MSB plane carries weight -2^(IN_BITS-1) for two's complement inputs.
  assign w_neg    = (SIGNED_IN != 0) && (r_bit == BW'(IN_BITS - 1));

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = COMPUTE;
          w_clear      = 1'b1;
        end
      end
      COMPUTE: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_plane[r] = r_in[r * IN_BITS + int'(r_bit)];
    end
  end

  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      for (int r = 0; r < ROWS; r++) begin
        w_wcol[j][r] = r_wmem[r][j];
      end
    end
  end

  // Weight storage has no reset so its contents survive a reset pulse.
  always_ff @(posedge Clk) begin
    if (bus.WE && (r_state == IDLE)) begin
      r_wmem[bus.w_addr] <= bus.w_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_in    <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_in  <= bus.In_B;
        r_bit <= BW'(IN_BITS - 1);
      end else if ((r_state == COMPUTE) && !w_last) begin
        r_bit <= r_bit - BW'(1);
      end
      if ((r_state == COMPUTE) && w_last) begin
        r_dout <= w_acc_next;
      end
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    cim_col_mac #(
      .ROWS    (ROWS),
      .IN_BITS (IN_BITS)
    ) u_col (
      .i_clk      (Clk),
      .i_rst_n    (Rst),
      .i_clear    (w_clear),
      .i_step     (w_step),
      .i_neg      (w_neg),
      .i_plane    (w_plane),
      .i_wcol     (w_wcol[j]),
      .o_acc_next (w_acc_next[lane_lo(j, ACC_W) +: ACC_W])
    );
  end

endmodule

// File: tb/tb_cim_macro_bitserial.sv
// Directed bench: an unsigned and a signed macro run in lockstep on the same stimulus.
module tb_cim_macro_bitserial;
  import cim_pkg::*;

  localparam int ROWS    = 128;
  localparam int COLS    = 64;
  localparam int IN_BITS = 4;
  localparam int ACC_W   = 13;
  localparam int IW      = ROWS * IN_BITS;
  localparam int DW      = COLS * ACC_W;

  logic   Clk;
  logic   Rst;
  state_e u_state;
  state_e s_state;
  int     total;
  int     bad;
  logic   last_in_ready;

  cim_macro_bitserial_if #(.ROWS(ROWS), .COLS(COLS), .IN_BITS(IN_BITS)) u_if ();
  cim_macro_bitserial_if #(.ROWS(ROWS), .COLS(COLS), .IN_BITS(IN_BITS)) s_if ();

  assign s_if.WE        = u_if.WE;
  assign s_if.w_addr    = u_if.w_addr;
  assign s_if.w_data    = u_if.w_data;
  assign s_if.in_valid  = u_if.in_valid;
  assign s_if.In_B      = u_if.In_B;
  assign s_if.out_ready = u_if.out_ready;

  cim_macro_bitserial #(.ROWS(ROWS), .COLS(COLS), .IN_BITS(IN_BITS), .SIGNED_IN(0)) dut_u (
    .Clk(Clk), .Rst(Rst), .bus(u_if), .o_dbg_state(u_state)
  );

  cim_macro_bitserial #(.ROWS(ROWS), .COLS(COLS), .IN_BITS(IN_BITS), .SIGNED_IN(1)) dut_s (
    .Clk(Clk), .Rst(Rst), .bus(s_if), .o_dbg_state(s_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic signed [ACC_W-1:0] col_of(input logic [DW-1:0] d, input int j);
    return d[j*ACC_W +: ACC_W];
  endfunction

  function automatic logic [IW-1:0] make_vec(input logic [3:0] v);
    logic [IW-1:0] m;
    for (int r = 0; r < ROWS; r++) m[r*IN_BITS +: IN_BITS] = v;
    return m;
  endfunction

  task automatic fill_weights(input bit triangle);
    for (int r = 0; r < ROWS; r++) begin
      @(negedge Clk);
      u_if.WE     = 1'b1;
      u_if.w_addr = 7'(r);
      for (int j = 0; j < COLS; j++) u_if.w_data[j] = triangle ? (r < j) : 1'b1;
    end
    @(negedge Clk);
    u_if.WE = 1'b0;
  endtask

  // Returns at the negedge after the accept edge, with in_valid dropped.
  task automatic send_accept(input logic [IW-1:0] v);
    @(negedge Clk);
    u_if.in_valid = 1'b1;
    u_if.In_B     = v;
    #1 last_in_ready = u_if.in_ready;
    @(posedge Clk);
    @(negedge Clk);
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [DW-1:0] du, output logic [DW-1:0] ds,
                             output int lat, output logic sv);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      if (u_if.out_valid) break;
    end
    du = u_if.DOut;
    ds = s_if.DOut;
    sv = s_if.out_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Rst = 1'b0;
    u_if.WE = 1'b0; u_if.w_addr = '0; u_if.w_data = '0;
    u_if.in_valid = 1'b0; u_if.In_B = '0; u_if.out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++; if (u_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", u_if.out_valid); end
    total++; if (u_if.DOut !== '0) begin bad++; $display("FAIL rst_dout got=%h want=0", u_if.DOut); end
    total++; if (u_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", u_if.in_ready); end
    total++; if (u_if.w_ready !== 1'b1) begin bad++; $display("FAIL rst_w_ready got=%b want=1", u_if.w_ready); end
    total++; if (u_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", u_state, IDLE); end
    Rst = 1'b1;
  endtask

  task automatic run_uniform(input string name, input logic [3:0] v, input int exp_u, input int exp_s);
    logic [DW-1:0] du, ds;
    int lat, nu, ns, fu, fs;
    logic sv;
    send_accept(make_vec(v));
    total++; if (last_in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", name, last_in_ready); end
    wait_result(du, ds, lat, sv);
    total++; if (lat !== 4) begin bad++; $display("FAIL %s_latency got=%0d want=4", name, lat); end
    total++; if (sv !== 1'b1) begin bad++; $display("FAIL %s_signed_valid got=%b want=1", name, sv); end
    nu = 0; ns = 0; fu = 0; fs = 0;
    for (int j = 0; j < COLS; j++) begin
      if (col_of(du, j) !== 13'(exp_u)) begin nu++; fu = j; end
      if (col_of(ds, j) !== 13'(exp_s)) begin ns++; fs = j; end
    end
    total++; if (nu != 0) begin bad++; $display("FAIL %s_unsigned col=%0d got=%0d want=%0d", name, fu, col_of(du, fu), exp_u); end
    total++; if (ns != 0) begin bad++; $display("FAIL %s_signed col=%0d got=%0d want=%0d", name, fs, col_of(ds, fs), exp_s); end
  endtask

  task automatic test_unit();
    fill_weights(1'b0);
    run_uniform("unit", 4'd1, 128, 128);
  endtask

  task automatic test_full_scale();
    run_uniform("max", 4'd15, 1920, -128);
    run_uniform("zero", 4'd0, 0, 0);
    run_uniform("msb", 4'd8, 1024, -1024);
  endtask

  task automatic test_triangle();
    logic [DW-1:0] du, ds;
    int lat, nb, fj;
    logic sv;
    fill_weights(1'b1);
    send_accept(make_vec(4'd3));
    wait_result(du, ds, lat, sv);
    total++; if (lat !== 4) begin bad++; $display("FAIL tri_latency got=%0d want=4", lat); end
    nb = 0; fj = 0;
    for (int j = 0; j < COLS; j++) begin
      if (col_of(du, j) !== 13'(3*j)) begin nb++; fj = j; end
      if (col_of(ds, j) !== 13'(3*j)) begin nb++; fj = j; end
    end
    total++; if (nb != 0) begin bad++; $display("FAIL tri_cols col=%0d got=%0d want=%0d", fj, col_of(du, fj), 3*fj); end
    total++; if (col_of(du, 63) !== 13'sd189) begin bad++; $display("FAIL tri_col63 got=%0d want=189", col_of(du, 63)); end
    total++; if (col_of(du, 0) !== 13'sd0) begin bad++; $display("FAIL tri_col0 got=%0d want=0", col_of(du, 0)); end
  endtask

  task automatic test_write_priority();
    logic [DW-1:0] du, ds, v1;
    int lat, nb, fj;
    logic sv;
    v1 = '0;
    v1[127*IN_BITS +: IN_BITS] = 4'd1;
    // Row 127 is all-zero under the triangle pattern; the write makes it all-ones.
    @(negedge Clk);
    u_if.WE = 1'b1; u_if.w_addr = 7'd127; u_if.w_data = '1;
    u_if.in_valid = 1'b1; u_if.In_B = v1;
    #1;
    total++; if (u_if.in_ready !== 1'b0) begin bad++; $display("FAIL wp_in_ready got=%b want=0", u_if.in_ready); end
    total++; if (u_if.w_ready !== 1'b1) begin bad++; $display("FAIL wp_w_ready got=%b want=1", u_if.w_ready); end
    @(negedge Clk);
    u_if.WE = 1'b0;
    total++; if (u_state !== IDLE) begin bad++; $display("FAIL wp_no_accept state=%0d want=%0d", u_state, IDLE); end
    @(posedge Clk);
    @(negedge Clk);
    u_if.in_valid = 1'b0;
    wait_result(du, ds, lat, sv);
    total++; if (lat !== 4) begin bad++; $display("FAIL wp_latency got=%0d want=4", lat); end
    nb = 0; fj = 0;
    for (int j = 0; j < COLS; j++) if (col_of(du, j) !== 13'sd1) begin nb++; fj = j; end
    total++; if (nb != 0) begin bad++; $display("FAIL wp_write_landed col=%0d got=%0d want=1", fj, col_of(du, fj)); end

    send_accept(v1);
    u_if.WE = 1'b1; u_if.w_addr = 7'd127; u_if.w_data = '0;
    #1;
    total++; if (u_if.w_ready !== 1'b0) begin bad++; $display("FAIL busy_w_ready got=%b want=0", u_if.w_ready); end
    wait_result(du, ds, lat, sv);
    u_if.WE = 1'b0;
    nb = 0; fj = 0;
    for (int j = 0; j < COLS; j++) if (col_of(du, j) !== 13'sd1) begin nb++; fj = j; end
    total++; if (nb != 0) begin bad++; $display("FAIL busy_stable col=%0d got=%0d want=1", fj, col_of(du, fj)); end

    send_accept(v1);
    wait_result(du, ds, lat, sv);
    nb = 0; fj = 0;
    for (int j = 0; j < COLS; j++) if (col_of(du, j) !== 13'sd1) begin nb++; fj = j; end
    total++; if (nb != 0) begin bad++; $display("FAIL busy_ignored col=%0d got=%0d want=1", fj, col_of(du, fj)); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] du, ds, held;
    int lat, nb, fj;
    logic sv;
    fill_weights(1'b0);
    u_if.out_ready = 1'b0;
    send_accept(make_vec(4'd2));
    wait_result(du, ds, lat, sv);
    held = du;
    nb = 0; fj = 0;
    for (int j = 0; j < COLS; j++) if (col_of(du, j) !== 13'sd256) begin nb++; fj = j; end
    total++; if (nb != 0) begin bad++; $display("FAIL bp_value col=%0d got=%0d want=256", fj, col_of(du, fj)); end
    for (int k = 0; k < 5; k++) begin
      u_if.in_valid = 1'b1;
      u_if.In_B     = make_vec(4'd5);
      @(posedge Clk);
      @(negedge Clk);
      total++; if (u_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", k, u_if.out_valid); end
      total++; if (u_if.DOut !== held) begin bad++; $display("FAIL bp_dout cyc=%0d got=%0d want=256", k, col_of(u_if.DOut, 0)); end
      total++; if (u_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, u_if.in_ready); end
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    total++; if (u_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", u_if.out_valid); end
    total++; if (u_if.DOut !== held) begin bad++; $display("FAIL bp_retain got=%0d want=256", col_of(u_if.DOut, 0)); end
    total++; if (u_state !== IDLE) begin bad++; $display("FAIL bp_release_state got=%0d want=%0d", u_state, IDLE); end
  endtask

  task automatic test_reset_abort();
    send_accept(make_vec(4'd1));
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    total++; if (u_if.out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", u_if.out_valid); end
    total++; if (u_if.DOut !== '0) begin bad++; $display("FAIL abort_dout got=%0d want=0", col_of(u_if.DOut, 0)); end
    total++; if (u_state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d want=%0d", u_state, IDLE); end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    total++; if (u_if.in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b want=1", u_if.in_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      total++; if (u_if.out_valid !== 1'b0) begin bad++; $display("FAIL abort_quiet cyc=%0d got=%b want=0", k, u_if.out_valid); end
    end
    run_uniform("rerun", 4'd1, 128, 128);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unit();
    test_full_scale();
    test_triangle();
    test_write_priority();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
